// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
//   in_*      : upstream valid/ready word stream (into the FIFO)
//   out_*     : downstream valid/ready word stream (out of the FIFO)
//   count     : words currently held by the controller
//   ram_*     : write port (data/write_addr/we) and read port (read_addr/q) of ram_dual_port
// The slave modport is the controller side; the master modport is its environment
// (producer, consumer and the RAM itself).
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_write_addr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  in_data, in_valid, out_ready, ram_q,
    output in_ready, out_data, out_valid, count,
    output ram_data, ram_write_addr, ram_we, ram_read_addr
  );

  modport master (
    output in_data, in_valid, out_ready, ram_q,
    input  in_ready, out_data, out_valid, count,
    input  ram_data, ram_write_addr, ram_we, ram_read_addr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapped around a dual-port RAM with a registered, always-enabled read.
// Ports:
//   clk   : single clock, rising-edge state updates (RAM clocks tied to it by the parent)
//   rst_n : asynchronous active-low reset; discards all queued words
//   bus   : ram_fifo_ctrl_if.slave -- input stream, output stream, count, RAM ports
// Capacity is 2^ADDR_W words in the RAM plus one in the output register.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] FullLevel = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StWait, StValid} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [ADDR_W:0] stored;
  logic            full;
  logic            can_fetch;
  logic            in_ready;
  logic            we;
  logic            busy;

  // Pointers carry a wrap bit so full and empty differ.
  assign stored    = wptr_q - rptr_q;
  assign full      = (stored == FullLevel);
  assign can_fetch = (stored != '0);

  // Registered pointers only: no path from out_ready to in_ready.
  assign in_ready = !full;
  assign we       = bus.in_valid & in_ready & rst_n;
  assign busy     = (state_q != StIdle);

  assign bus.in_ready       = in_ready;
  assign bus.ram_we         = we;
  assign bus.ram_data       = bus.in_data;
  assign bus.ram_write_addr = wptr_q[ADDR_W-1:0];
  assign bus.ram_read_addr  = rptr_q[ADDR_W-1:0];
  assign bus.out_data       = out_data_q;
  assign bus.out_valid      = out_valid_q;
  // A slot is released at its fetch edge; the word in flight or in the output register
  // is still counted through busy.
  assign bus.count          = stored + {{ADDR_W{1'b0}}, busy};

  assign wptr_d = wptr_q + {{ADDR_W{1'b0}}, we};

  // Fetching means advancing rptr: the RAM latches mem[old rptr] on that same edge,
  // and the word is captured from ram_q in StWait.
  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (can_fetch) begin
          rptr_d  = rptr_q + 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        out_data_d  = bus.ram_q;
        out_valid_d = 1'b1;
        state_d     = StValid;
      end
      StValid: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (can_fetch) begin
            rptr_d  = rptr_q + 1'b1;
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural ram_dual_port model and a scoreboard queue.
module tb_ram_fifo_ctrl;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;

  logic clk;
  logic rst_n;

  ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read on every edge, no read enable.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_read_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard and occupancy model, updated once per cycle on the falling edge.
  logic [DATA_W-1:0] sb[$];
  int model_count = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      model_count = 0;
      prev_hold = 1'b0;
    end else begin
      chk("mon_count", 32'(bus.count), 32'(model_count));
      if (prev_hold) chk("out_data_stable", 32'(bus.out_data), 32'(prev_data));
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_out_data", 32'(bus.out_data), 32'(sb.pop_front()));
        end
        model_count--;
        n_pop++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(bus.in_data);
        model_count++;
        n_acc++;
      end
    end
  end

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_write_addr", 32'(bus.ram_write_addr), 32'd0);
    chk("rst_read_addr", 32'(bus.ram_read_addr), 32'd0);
  endtask

  // Reset asserted mid-cycle; in_valid may be held high to show ram_we is gated.
  task automatic do_reset(input logic iv_hold);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.in_valid  = iv_hold;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic              pre_rst;
    logic              iv;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              e_ir;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic [ADDR_W:0]   e_cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int pop0;
    int cyc;
    int accepted;
    logic seen;

    // Single word, then (after a reset) three-word ordering with stalled consumer.
    tbl[0]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 7'd1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hAA, 7'd0};
    tbl[5]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 8'h00, 7'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 7'd2};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 7'd3};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 7'd3};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hAA, 7'd2};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB3, 7'd2};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB3, 7'd1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hF0, 7'd1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hF0, 7'd0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pre_rst) do_reset(1'b0);
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
    end

    // Fill: consumer stalled, offer words until in_ready drops.
    do_reset(1'b0);
    accepted = 0;
    for (int c = 0; c < 100 && accepted < 65; c++) begin
      drive(1'b1, 8'(accepted), 1'b0);
      if (bus.in_ready) accepted++;
    end
    chk("fill_accepted", 32'(accepted), 32'd65);
    drive(1'b1, 8'd65, 1'b0);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_count", 32'(bus.count), 32'd65);
    chk("fill_ram_we", 32'(bus.ram_we), 32'd0);

    // Full with a fetch on the same edge: write still refused.
    drive(1'b1, 8'd65, 1'b1);
    chk("fullfetch_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fullfetch_ram_we", 32'(bus.ram_we), 32'd0);
    drive(1'b0, 8'd0, 1'b0);
    chk("fullfetch_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("fullfetch_count_after", 32'(bus.count), 32'd64);

    // Drain: scoreboard checks 1..64 in order (0 left on the fetch edge above).
    cyc = 0;
    while (bus.count != 0 && cyc < 400) begin
      drive(1'b0, 8'd0, 1'b1);
      cyc++;
    end
    chk("drain_done", 32'(bus.count), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Wrap-around with random flow control.
    acc0 = n_acc;
    pop0 = n_pop;
    cyc  = 0;
    while ((n_pop - pop0) < 200 && cyc < 5000) begin
      drive(((n_acc - acc0) < 200) ? 1'($urandom_range(0, 1)) : 1'b0, 8'(n_acc - acc0),
            1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("wrap_popped", 32'(n_pop - pop0), 32'd200);
    chk("wrap_pushed", 32'(n_acc - acc0), 32'd200);
    drive(1'b0, 8'd0, 1'b0);
    chk("wrap_count_zero", 32'(bus.count), 32'd0);

    // Reset mid-stream with five words held and the output valid.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 1'b0);
    chk("mid_count", 32'(bus.count), 32'd5);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_out_data", 32'(bus.out_data), 32'h10);
    do_reset(1'b1);
    drive(1'b1, 8'h3C, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      drive(1'b0, 8'd0, 1'b1);
      if (bus.out_valid) begin
        seen = 1'b1;
        chk("post_rst_data", 32'(bus.out_data), 32'h3C);
      end
    end
    chk("post_rst_seen", 32'(seen), 32'd1);
    drive(1'b0, 8'd0, 1'b1);
    drive(1'b0, 8'd0, 1'b1);
    chk("post_rst_count", 32'(bus.count), 32'd0);
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
